// File: rtl/rpn_sequencer.sv
// Program player for the 16-bit RPN stack calculator: replays a stored program one
// command per clock, mirrors stack depth, and rejects programs that would underflow/overflow.
module rpn_sequencer #(
    parameter int ADDR_W    = 6,
    parameter int MAX_DEPTH = 1023
) (
    input  logic              step,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [19:0]       prog_data,
    input  logic              start,
    input  logic [15:0]       calc_out,
    output logic              calc_nrst,
    output logic [15:0]       d,
    output logic              push,
    output logic [1:0]        op,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       result,
    output logic [9:0]        depth,
    output logic [2:0]        fsm_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [9:0]      MAX_D  = 10'(MAX_DEPTH);
    localparam logic [ADDR_W:0] PC_INC = {{ADDR_W{1'b0}}, 1'b1};

    logic [19:0]       mem [2**ADDR_W];
    logic [2:0]        state;
    // Extra top bit marks "ran past the last word"; it is never used to index the store.
    logic [ADDR_W:0]   pc;
    logic [19:0]       instr;
    logic              unused_bits;

    assign instr       = mem[pc[ADDR_W-1:0]];
    assign unused_bits = ^instr[17:16];
    assign busy        = (state == S_CLEAR) || (state == S_RUN) || (state == S_DRAIN);
    assign done        = (state == S_DONE);
    assign err         = (state == S_ERR);
    assign fsm_state   = state;

    always_ff @(posedge step) begin
        if (prog_we && !busy)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge step or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            push      <= 1'b0;
            op        <= 2'b00;
            d         <= '0;
            calc_nrst <= 1'b0;
            result    <= '0;
            depth     <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    calc_nrst <= 1'b1;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    push <= 1'b0;
                    op   <= 2'b00;
                    if (pc[ADDR_W]) begin
                        state <= S_ERR;
                    end else begin
                        case (instr[19:18])
                            2'b00: begin
                                if (depth == MAX_D) begin
                                    state <= S_ERR;
                                end else begin
                                    push  <= 1'b1;
                                    d     <= instr[15:0];
                                    depth <= depth + 10'd1;
                                    pc    <= pc + PC_INC;
                                end
                            end
                            2'b01: begin
                                case (instr[1:0])
                                    2'b00: pc <= pc + PC_INC;
                                    2'b01: begin
                                        if (depth != 10'd0) begin
                                            op <= 2'b01;
                                            pc <= pc + PC_INC;
                                        end else begin
                                            state <= S_ERR;
                                        end
                                    end
                                    default: begin
                                        if (depth > 10'd1) begin
                                            op    <= instr[1:0];
                                            depth <= depth - 10'd1;
                                            pc    <= pc + PC_INC;
                                        end else begin
                                            state <= S_ERR;
                                        end
                                    end
                                endcase
                            end
                            2'b10: begin
                                if (depth == 10'd0) state <= S_ERR;
                                else                state <= S_DRAIN;
                            end
                            default: pc <= pc + PC_INC;
                        endcase
                    end
                end
                S_DRAIN: begin
                    result <= calc_out;
                    state  <= S_DONE;
                end
                default: begin
                    push      <= 1'b0;
                    op        <= 2'b00;
                    calc_nrst <= 1'b1;
                    if (start) begin
                        state     <= S_CLEAR;
                        calc_nrst <= 1'b0;
                        pc        <= '0;
                        depth     <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer: a behavioural calculator closes the loop, a scoreboard
// queue holds expected {err, depth, result} and a monitor checks on each completion.
module tb_rpn_sequencer;

    logic        step = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [19:0] prog_data;
    logic        start;
    logic [15:0] calc_out;
    logic        calc_nrst;
    logic [15:0] d;
    logic        push;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] result;
    logic [9:0]  depth;
    logic [2:0]  fsm_state;

    int checks   = 0;
    int failures = 0;

    logic [26:0] exp_q[$];
    logic [19:0] prog_buf [64];
    logic        saw_add;

    rpn_sequencer #(.ADDR_W(6), .MAX_DEPTH(1023)) dut (
        .step(step), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .calc_out(calc_out),
        .calc_nrst(calc_nrst), .d(d), .push(push), .op(op), .busy(busy),
        .done(done), .err(err), .result(result), .depth(depth),
        .fsm_state(fsm_state)
    );

    always #5 step = ~step;

    // Behavioural calculator: executes the registered command bus on each rising edge.
    logic [15:0] stk [1024];
    int          sp;
    always @(posedge step) begin
        if (!calc_nrst) begin
            sp <= 0;
        end else if (push) begin
            stk[sp] <= d;
            sp      <= sp + 1;
        end else begin
            case (op)
                2'b01: stk[sp-1] <= 16'(0 - stk[sp-1]);
                2'b10: begin stk[sp-2] <= stk[sp-2] + stk[sp-1]; sp <= sp - 1; end
                2'b11: begin stk[sp-2] <= 16'(stk[sp-2] * stk[sp-1]); sp <= sp - 1; end
                default: ;
            endcase
        end
    end
    assign calc_out = (sp > 0) ? stk[sp-1] : 16'h0000;

    function automatic logic [19:0] w_push(input logic [15:0] imm);
        return {4'b0000, imm};
    endfunction
    function automatic logic [19:0] w_op(input logic [1:0] c);
        return {2'b01, 16'h0000, c};
    endfunction
    localparam logic [19:0] W_HALT = 20'h80000;
    localparam logic [19:0] W_NOP  = 20'hC0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation whenever done or err rises.
    logic flag_prev = 1'b0;
    initial begin
        forever begin
            @(negedge step);
            if (op == 2'b10) saw_add = 1'b1;
            if ((done || err) && !flag_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got err=%0b depth=%0d result=%0h with empty queue",
                             err, depth, result);
                end else begin
                    logic [26:0] e;
                    e = exp_q.pop_front();
                    if ({err, depth, result} !== e || done === err) begin
                        failures++;
                        $display("FAIL sb_completion: got err=%0b done=%0b depth=%0d result=%0h expected err=%0b depth=%0d result=%0h",
                                 err, done, depth, result, e[26], e[25:16], e[15:0]);
                    end
                end
            end
            flag_prev = done || err;
        end
    end

    task automatic load_prog(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge step);
            prog_we   = 1'b1;
            prog_addr = 6'(i);
            prog_data = prog_buf[i];
        end
        @(negedge step);
        prog_we = 1'b0;
    endtask

    task automatic load_a();
        prog_buf[0] = w_push(16'd3);
        prog_buf[1] = w_push(16'd4);
        prog_buf[2] = w_op(2'b10);
        prog_buf[3] = w_push(16'd5);
        prog_buf[4] = w_op(2'b11);
        prog_buf[5] = W_HALT;
        load_prog(6);
    endtask

    // Starts a run and waits for completion; lat counts edges after the start-sampling edge.
    task automatic do_run(input string name, input int lat, input logic e,
                          input logic [15:0] r, input logic [9:0] dp, input bit inject);
        int cnt;
        exp_q.push_back({e, dp, r});
        @(negedge step);
        start = 1'b1;
        @(negedge step);
        start = 1'b0;
        cnt = 0;
        while (cnt < 200) begin
            @(negedge step);
            cnt++;
            if (inject && cnt == 3) begin
                prog_we   = 1'b1;
                prog_addr = 6'd0;
                prog_data = w_push(16'd7);
                start     = 1'b1;
            end
            if (inject && cnt == 4) begin
                prog_we = 1'b0;
                start   = 1'b0;
            end
            if (done || err) break;
        end
        chk({name, "_latency"}, 32'(cnt), 32'(lat));
    endtask

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
        saw_add = 1'b0;
        #23;
        chk("rst_calc_nrst", 32'(calc_nrst), 0);
        chk("rst_push",      32'(push), 0);
        chk("rst_op",        32'(op), 0);
        chk("rst_d",         32'(d), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_done",      32'(done), 0);
        chk("rst_err",       32'(err), 0);
        chk("rst_result",    32'(result), 0);
        chk("rst_depth",     32'(depth), 0);
        chk("rst_state",     32'(fsm_state), 0);
        @(negedge step);
        rst = 1'b0;
        @(negedge step);
        chk("idle_calc_nrst", 32'(calc_nrst), 1);

        load_a();
        do_run("prog_a", 8, 1'b0, 16'h0023, 10'd1, 1'b0);

        prog_buf[0] = w_push(16'h8000);
        prog_buf[1] = w_push(16'h0002);
        prog_buf[2] = w_op(2'b11);
        prog_buf[3] = W_HALT;
        load_prog(4);
        do_run("mul_wrap", 6, 1'b0, 16'h0000, 10'd1, 1'b0);

        prog_buf[0] = w_push(16'd5);
        prog_buf[1] = w_op(2'b01);
        prog_buf[2] = W_HALT;
        load_prog(3);
        do_run("negate", 5, 1'b0, 16'hFFFB, 10'd1, 1'b0);

        prog_buf[0] = w_push(16'd1);
        prog_buf[1] = w_op(2'b10);
        prog_buf[2] = W_HALT;
        load_prog(3);
        saw_add = 1'b0;
        do_run("underflow", 3, 1'b1, 16'hFFFB, 10'd1, 1'b0);
        repeat (2) @(negedge step);
        chk("underflow_no_add", 32'(saw_add), 0);
        chk("underflow_no_done", 32'(done), 0);

        prog_buf[0] = W_HALT;
        load_prog(1);
        do_run("empty_halt", 2, 1'b1, 16'hFFFB, 10'd0, 1'b0);

        for (int i = 0; i < 64; i++) prog_buf[i] = W_NOP;
        load_prog(64);
        do_run("run_off_end", 66, 1'b1, 16'hFFFB, 10'd0, 1'b0);

        load_a();
        @(negedge step);
        start = 1'b1;
        @(negedge step);
        start = 1'b0;
        repeat (3) @(negedge step);
        chk("midrun_busy_before", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("midrun_calc_nrst", 32'(calc_nrst), 0);
        chk("midrun_push",      32'(push), 0);
        chk("midrun_busy",      32'(busy), 0);
        chk("midrun_result",    32'(result), 0);
        @(negedge step);
        rst = 1'b0;
        do_run("rerun_a", 8, 1'b0, 16'h0023, 10'd1, 1'b0);

        do_run("inject", 8, 1'b0, 16'h0023, 10'd1, 1'b1);
        do_run("store_kept", 8, 1'b0, 16'h0023, 10'd1, 1'b0);

        repeat (3) @(negedge step);
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
